arb_mux_reg: RTL and testbench

- N-channel, parametrised successor to the fixed 3-input datapath select.
- Chooses one of NUM_CH valid/ready source channels and forwards its data into a single registered output stage with a valid/ready handshake.
- Selection is one of: fixed priority, round-robin, or forced by an explicit select input.
- Sits where several pipeline requesters share one downstream port, e.g. IF and MEM sharing a memory bus port.

---
 rtl/arb_mux_reg.sv | 100 ++++++++++
 tb/tb_arb_mux_reg.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/arb_mux_reg.sv
// arb_mux_reg: N-channel valid/ready arbiter feeding one registered output
// stage. Fixed-priority, round-robin or forced selection.
//
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   valid_i, data_i      per-channel requests, channel k data at k*DATA_WIDTH
//   ready_o              per-channel accept (combinational, one-hot or zero)
//   force_en_i           forced-select mode enable
//   force_sel_i          channel used while forced
//   valid_o, data_o      registered output word and its valid
//   ch_o                 index of the channel that supplied data_o
//   ready_i              downstream accept
module arb_mux_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 3,
  parameter int SEL_W      = $clog2(NUM_CH),
  parameter bit RR_EN      = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_CH-1:0]            valid_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_i,
  output logic [NUM_CH-1:0]            ready_o,
  input  logic                         force_en_i,
  input  logic [SEL_W-1:0]             force_sel_i,
  output logic                         valid_o,
  output logic [DATA_WIDTH-1:0]        data_o,
  output logic [SEL_W-1:0]             ch_o,
  input  logic                         ready_i
);

  logic [SEL_W-1:0]      ptr_q;
  logic                  load_ok;
  logic                  gnt_vld;
  logic [SEL_W-1:0]      gnt;
  logic [DATA_WIDTH-1:0] gnt_data;

  assign load_ok = !valid_o || ready_i;

  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt     = '0;
    if (force_en_i) begin
      // Out-of-range selects match no channel, so they never grant.
      for (int k = 0; k < NUM_CH; k++) begin
        if (force_sel_i == SEL_W'(k) && valid_i[k]) begin
          gnt_vld = 1'b1;
          gnt     = SEL_W'(k);
        end
      end
    end else if (!RR_EN) begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        if (valid_i[k]) begin
          gnt_vld = 1'b1;
          gnt     = SEL_W'(k);
        end
      end
    end else begin
      // Search ptr, ptr+1, ... with explicit wrap (NUM_CH may not be 2^n).
      for (int i = 0; i < NUM_CH; i++) begin
        idx = int'(ptr_q) + i;
        if (idx >= NUM_CH) idx = idx - NUM_CH;
        if (!gnt_vld && valid_i[idx]) begin
          gnt_vld = 1'b1;
          gnt     = SEL_W'(idx);
        end
      end
    end
    if (!load_ok || !rst_ni) gnt_vld = 1'b0;
  end

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      ready_o[k] = gnt_vld && (gnt == SEL_W'(k));
    end
  end

  assign gnt_data = data_i[int'(gnt)*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      ch_o    <= '0;
      ptr_q   <= '0;
    end else if (gnt_vld) begin
      valid_o <= 1'b1;
      data_o  <= gnt_data;
      ch_o    <= gnt;
      if (RR_EN) begin
        ptr_q <= (int'(gnt) == NUM_CH - 1) ? '0 : gnt + SEL_W'(1);
      end
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arb_mux_reg.sv
// tb_arb_mux_reg: directed checks of arb_mux_reg, one round-robin and one
// fixed-priority instance sharing the same stimulus.
module tb_arb_mux_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  valid;
  logic [95:0] data;
  logic        force_en;
  logic [1:0]  force_sel;
  logic        rdy;

  logic [2:0]  a_ready, b_ready;
  logic        a_valid, b_valid;
  logic [31:0] a_data, b_data;
  logic [1:0]  a_ch, b_ch;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  arb_mux_reg #(.DATA_WIDTH(32), .NUM_CH(3), .RR_EN(1'b1)) u_rr (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .data_i(data),
    .ready_o(a_ready), .force_en_i(force_en), .force_sel_i(force_sel),
    .valid_o(a_valid), .data_o(a_data), .ch_o(a_ch), .ready_i(rdy)
  );

  arb_mux_reg #(.DATA_WIDTH(32), .NUM_CH(3), .RR_EN(1'b0)) u_fp (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .data_i(data),
    .ready_o(b_ready), .force_en_i(force_en), .force_sel_i(force_sel),
    .valid_o(b_valid), .data_o(b_data), .ch_o(b_ch), .ready_i(rdy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    valid     = 3'b111;
    data      = {32'h33, 32'h22, 32'h11};
    force_en  = 1'b0;
    force_sel = 2'd0;
    rdy       = 1'b1;

    step();
    step();
    chk("rst_valid", 32'(a_valid), 32'd0);
    chk("rst_data", a_data, 32'h0);
    chk("rst_ch", 32'(a_ch), 32'd0);
    chk("rst_ready", 32'(a_ready), 32'd0);
    chk("rst_ready_fp", 32'(b_ready), 32'd0);
    rst_n = 1'b1;

    step();
    chk("rr0_valid", 32'(a_valid), 32'd1);
    chk("rr0_ch", 32'(a_ch), 32'd0);
    chk("rr0_data", a_data, 32'h11);
    chk("fp0_ch", 32'(b_ch), 32'd0);
    step();
    chk("rr1_ch", 32'(a_ch), 32'd1);
    chk("rr1_data", a_data, 32'h22);
    chk("fp1_ch", 32'(b_ch), 32'd0);
    step();
    chk("rr2_ch", 32'(a_ch), 32'd2);
    chk("rr2_data", a_data, 32'h33);
    step();
    chk("rr3_ch", 32'(a_ch), 32'd0);
    chk("rr3_data", a_data, 32'h11);

    valid = 3'b110;
    step();
    chk("fp110_a", 32'(b_ch), 32'd1);
    step();
    chk("fp110_b", 32'(b_ch), 32'd1);
    chk("fp110_data", b_data, 32'h22);
    valid = 3'b100;
    step();
    chk("fp100_ch", 32'(b_ch), 32'd2);

    // rr pointer is now 0 (last rr grant was ch2)
    data  = {32'h33, 32'h22, 32'hDEADBEEF};
    valid = 3'b001;
    step();
    chk("bp_load", a_data, 32'hDEADBEEF);
    rdy   = 1'b0;
    valid = 3'b111;
    data  = {32'h33, 32'h22, 32'h11};
    #1;
    chk("bp_ready", 32'(a_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_hold_data", a_data, 32'hDEADBEEF);
      chk("bp_hold_valid", 32'(a_valid), 32'd1);
      chk("bp_hold_ready", 32'(a_ready), 32'd0);
    end
    rdy = 1'b1;
    #1;
    chk("bp_release_ready", 32'(a_ready), 32'b010);
    step();
    chk("bp_refill_valid", 32'(a_valid), 32'd1);
    chk("bp_refill_ch", 32'(a_ch), 32'd1);
    chk("bp_refill_data", a_data, 32'h22);

    force_en  = 1'b1;
    force_sel = 2'd2;
    valid     = 3'b011;
    #1;
    chk("frc_noreq_ready", 32'(a_ready), 32'd0);
    step();
    chk("frc_drain_valid", 32'(a_valid), 32'd0);
    valid = 3'b111;
    #1;
    chk("frc_ready", 32'(a_ready), 32'b100);
    chk("frc_ready_fp", 32'(b_ready), 32'b100);
    step();
    chk("frc_ch", 32'(a_ch), 32'd2);
    chk("frc_data", a_data, 32'h33);
    force_sel = 2'd3;
    #1;
    chk("frc3_ready", 32'(a_ready), 32'd0);
    step();
    chk("frc3_valid", 32'(a_valid), 32'd0);

    // ptr is 0 after the forced ch2 transfer
    force_en = 1'b0;
    step();
    chk("mid_load_ch", 32'(a_ch), 32'd0);
    rdy = 1'b0;
    step();
    chk("mid_hold_valid", 32'(a_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(a_ready), 32'd0);
    step();
    chk("mid_rst_valid", 32'(a_valid), 32'd0);
    chk("mid_rst_data", a_data, 32'h0);
    rst_n = 1'b1;
    rdy   = 1'b1;
    step();
    chk("post_rst_ch", 32'(a_ch), 32'd0);
    chk("post_rst_valid", 32'(a_valid), 32'd1);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
